// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I decode stage. Decodes the fetched instruction word in the same cycle.
//   The register-file read addresses come straight from the instruction bits.
//   The result is loaded into one output slot that has a valid/ready handshake
//   towards the execute-stage ALU. The slot supports stall (ex_ready low) and
//   flush.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_if_valid/o_if_ready   fetch handshake
//   i_if_instr, i_if_pc     instruction word and its PC
//   o_rs1_addr/o_rs2_addr   combinational regfile read addresses
//   i_rs1_data/i_rs2_data   regfile read data, same cycle
//   i_flush                 drop the held and the incoming instruction
//   o_ex_valid/i_ex_ready   execute handshake
//   o_ex_alu_op             ALU operation:
//                             0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU,
//                             5 XOR, 6 SRL, 7 SRA, 8 OR,  9 AND
//   o_ex_op_a/o_ex_op_b     ALU operands
//   o_ex_rd, o_ex_reg_write writeback destination and enable
//   o_ex_illegal            instruction not decodable
//   o_ex_pc                 PC of the held instruction
//
// Parameters
//   XLEN          datapath width; only 32 is supported
//   CHECK_FUNCT7  1: reject funct7 encodings outside the legal set;
//                 0: only instr[30] is looked at
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN         = 32,
  parameter bit CHECK_FUNCT7 = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  input  logic [31:0]     i_if_instr,
  input  logic [XLEN-1:0] i_if_pc,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [3:0]      o_ex_alu_op,
  output logic [XLEN-1:0] o_ex_op_a,
  output logic [XLEN-1:0] o_ex_op_b,
  output logic [4:0]      o_ex_rd,
  output logic            o_ex_reg_write,
  output logic            o_ex_illegal,
  output logic [XLEN-1:0] o_ex_pc
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // funct3 -> ALU operation. The alt bit selects SUB or SRA.
  function automatic alu_op_t f_alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    f_alu_map = alt ? ALU_SUB : ALU_ADD;
      3'd1:    f_alu_map = ALU_SLL;
      3'd2:    f_alu_map = ALU_SLT;
      3'd3:    f_alu_map = ALU_SLTU;
      3'd4:    f_alu_map = ALU_XOR;
      3'd5:    f_alu_map = alt ? ALU_SRA : ALU_SRL;
      3'd6:    f_alu_map = ALU_OR;
      default: f_alu_map = ALU_AND;
    endcase
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic            w_f7_zero;
  logic            w_f7_alt;
  logic            w_accept;
  alu_op_t         w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_illegal;

  logic            r_valid;
  alu_op_t         r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_illegal;
  logic [XLEN-1:0] r_pc;

  assign w_opcode   = i_if_instr[6:0];
  assign w_rd       = i_if_instr[11:7];
  assign w_f3       = i_if_instr[14:12];
  assign w_f7       = i_if_instr[31:25];
  assign w_f7_zero  = (w_f7 == 7'b0000000);
  assign w_f7_alt   = (w_f7 == 7'b0100000);

  assign o_rs1_addr = i_if_instr[19:15];
  assign o_rs2_addr = i_if_instr[24:20];

  assign o_if_ready = !i_flush && (!r_valid || i_ex_ready);
  assign w_accept   = i_if_valid && o_if_ready;

  always_comb begin
    w_op      = ALU_ADD;
    w_a       = '0;
    w_b       = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_a  = i_rs1_data;
        w_b  = i_rs2_data;
        w_op = f_alu_map(w_f3, i_if_instr[30]);
        // The alternate encoding exists only for SUB and SRA.
        if (CHECK_FUNCT7 && !(w_f7_zero || (w_f7_alt && (w_f3 == 3'd0 || w_f3 == 3'd5))))
          w_illegal = 1'b1;
      end
      OPC_OPIMM: begin
        w_a  = i_rs1_data;
        w_b  = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
        // instr[30] is part of the immediate except for the right shifts.
        w_op = f_alu_map(w_f3, (w_f3 == 3'd5) && i_if_instr[30]);
        if (w_f3 == 3'd1 || w_f3 == 3'd5) begin
          w_b = {27'd0, i_if_instr[24:20]};
          if (CHECK_FUNCT7 && !(w_f7_zero || (w_f7_alt && w_f3 == 3'd5)))
            w_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        w_b = {i_if_instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        w_a = i_if_pc;
        w_b = {i_if_instr[31:12], 12'd0};
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_op = ALU_ADD;
      w_a  = '0;
      w_b  = '0;
    end
  end

  // Output slot. Flush wins over accept. The payload changes only on accept,
  // so it stays stable while stalled and after a flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_op        <= ALU_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
      r_pc        <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_op        <= w_op;
      r_a         <= w_a;
      r_b         <= w_b;
      r_rd        <= w_rd;
      r_reg_write <= !w_illegal && (w_rd != 5'd0);
      r_illegal   <= w_illegal;
      r_pc        <= i_if_pc;
    end else if (i_ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ex_valid     = r_valid;
  assign o_ex_alu_op    = r_op;
  assign o_ex_op_a      = r_a;
  assign o_ex_op_b      = r_b;
  assign o_ex_rd        = r_rd;
  assign o_ex_reg_write = r_reg_write;
  assign o_ex_illegal   = r_illegal;
  assign o_ex_pc        = r_pc;

endmodule
